adc_serial_reader: RTL and testbench

Serial ADC capture block; the input-side counterpart of the team's 8-bit DAC ramp driver. Drives chip-select and serial clock of an ADC0831-class serial converter, discards the leading null bit(s), shifts in an MSB-first sample, and presents it as a parallel word with a one-cycle valid strobe. It sits between the converter pins and the control logic that consumes sampled values.

---
 rtl/adc_serial_reader_pkg.sv | 20 ++
 rtl/adc_serial_reader_sclk_gen.sv | 48 ++++
 rtl/adc_serial_reader.sv | 181 ++++++++++++++++++
 tb/tb_adc_serial_reader.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_serial_reader_pkg.sv
// adc_reader_pkg: state encoding and default constants shared by adc_serial_reader.
// Build option ADC_READER_AVG_EN uses AVG_COUNT/AVG_SHIFT.
package adc_reader_pkg;

  localparam int DEF_CLK_DIV    = 4;
  localparam int DEF_SETUP_BITS = 1;
  localparam int DEF_DATA_W     = 8;

  // Averaging: four conversions, divide by shifting right two places.
  localparam int AVG_COUNT = 4;
  localparam int AVG_SHIFT = 2;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SETUP = 2'd1;
  localparam state_t ST_SHIFT = 2'd2;
  localparam state_t ST_HOLD  = 2'd3;

endpackage

// File: rtl/adc_serial_reader_sclk_gen.sv
// sclk_gen: divides clk into SCLK half-periods of CLK_DIV cycles while run is high;
// flags the last cycle of each high phase (hi_end) and of each low phase (lo_end).
module sclk_gen
  import adc_reader_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic sclk,
  output logic hi_end,
  output logic lo_end
);

  localparam int DIV_W = $clog2(CLK_DIV);

  logic [DIV_W-1:0] cnt;
  logic             active;
  logic             tc;

  assign tc = (cnt == '0);

  // cnt parks at zero when stopped so the first enabled edge raises sclk at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      sclk   <= 1'b0;
      active <= 1'b0;
    end else if (!run) begin
      cnt    <= '0;
      sclk   <= 1'b0;
      active <= 1'b0;
    end else begin
      active <= 1'b1;
      if (tc) begin
        sclk <= ~sclk;
        cnt  <= DIV_W'(CLK_DIV - 1);
      end else begin
        cnt <= cnt - DIV_W'(1);
      end
    end
  end

  assign hi_end = sclk & tc;
  assign lo_end = active & ~sclk & tc;

endmodule

// File: rtl/adc_serial_reader.sv
// adc_serial_reader: ADC0831-class serial capture; drives cs_n/sclk, drops the null bit(s),
// returns an MSB-first word. Build option ADC_READER_AVG_EN: average four conversions per start.
//
// state | meaning
// IDLE  | cs_n high, sclk low, waiting for start
// SETUP | cs_n low, sclk low for one half-period
// SHIFT | SETUP_BITS+DATA_W sclk periods; adc_do sampled at end of each high phase
// HOLD  | cs_n high for one half-period; result published on entry
module adc_serial_reader
  import adc_reader_pkg::*;
#(
  parameter int CLK_DIV    = DEF_CLK_DIV,
  parameter int SETUP_BITS = DEF_SETUP_BITS,
  parameter int DATA_W     = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              adc_do,
  output logic              adc_cs_n,
  output logic              adc_sclk,
  output logic [DATA_W-1:0] sample,
  output logic              sample_valid,
  output logic              null_err,
  output logic              busy
);

  localparam int N     = SETUP_BITS + DATA_W;
  localparam int BIT_W = $clog2(N);
  localparam int DIV_W = $clog2(CLK_DIV);

  state_t            state;
  state_t            state_nx;
  logic [DIV_W-1:0]  div_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic              nerr_acc;
  logic              adc_meta;
  logic              adc_sync;
  logic              sclk_run;
  logic              hi_end;
  logic              lo_end;
  logic              div_tc;
  logic              last_conv;
  logic              enter_setup;
  logic              enter_hold;

  assign div_tc      = (div_cnt == '0);
  assign enter_setup = (state_nx == ST_SETUP) && (state != ST_SETUP);
  assign enter_hold  = (state == ST_SHIFT) && (state_nx == ST_HOLD);
  assign sclk_run    = (state_nx == ST_SHIFT);

  sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (sclk_run),
    .sclk   (adc_sclk),
    .hi_end (hi_end),
    .lo_end (lo_end)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adc_meta <= 1'b0;
      adc_sync <= 1'b0;
    end else begin
      adc_meta <= adc_do;
      adc_sync <= adc_meta;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (start) state_nx = ST_SETUP;
      ST_SETUP: if (div_tc) state_nx = ST_SHIFT;
      ST_SHIFT: if (lo_end && bit_cnt == '0) state_nx = ST_HOLD;
      ST_HOLD:  if (div_tc) state_nx = last_conv ? ST_IDLE : ST_SETUP;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Pin-side outputs are registered from the next state so they change with the state itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      nerr_acc <= 1'b0;
      adc_cs_n <= 1'b1;
      busy     <= 1'b0;
    end else begin
      state    <= state_nx;
      adc_cs_n <= (state_nx == ST_IDLE) || (state_nx == ST_HOLD);
      busy     <= (state_nx != ST_IDLE);
      if (state_nx != state) begin
        div_cnt <= DIV_W'(CLK_DIV - 1);
      end else if (!div_tc) begin
        div_cnt <= div_cnt - DIV_W'(1);
      end
      if (enter_setup) begin
        bit_cnt  <= BIT_W'(N - 1);
        shreg    <= '0;
        nerr_acc <= 1'b0;
      end else if (state == ST_SHIFT) begin
        if (hi_end) begin
          if (bit_cnt >= BIT_W'(DATA_W)) begin
            nerr_acc <= nerr_acc | adc_sync;
          end else begin
            shreg <= {shreg[DATA_W-2:0], adc_sync};
          end
        end
        if (lo_end && bit_cnt != '0) begin
          bit_cnt <= bit_cnt - BIT_W'(1);
        end
      end
    end
  end

`ifdef ADC_READER_AVG_EN
  localparam int SUM_W  = DATA_W + 2;
  localparam int CONV_W = $clog2(AVG_COUNT);

  logic [CONV_W-1:0] conv_cnt;
  logic [SUM_W-1:0]  sum_acc;
  logic [SUM_W-1:0]  sum_nx;
  logic              nerr_all;

  assign last_conv = (conv_cnt == '0);
  assign sum_nx    = sum_acc + SUM_W'(shreg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conv_cnt     <= '0;
      sum_acc      <= '0;
      nerr_all     <= 1'b0;
      sample       <= '0;
      null_err     <= 1'b0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (state == ST_IDLE && state_nx == ST_SETUP) begin
        conv_cnt <= CONV_W'(AVG_COUNT - 1);
        sum_acc  <= '0;
        nerr_all <= 1'b0;
      end else if (state == ST_HOLD && state_nx == ST_SETUP) begin
        conv_cnt <= conv_cnt - CONV_W'(1);
      end
      if (enter_hold) begin
        sum_acc  <= sum_nx;
        nerr_all <= nerr_all | nerr_acc;
        if (last_conv) begin
          sample       <= DATA_W'(sum_nx >> AVG_SHIFT);
          null_err     <= nerr_all | nerr_acc;
          sample_valid <= 1'b1;
        end
      end
    end
  end
`else
  assign last_conv = 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample       <= '0;
      null_err     <= 1'b0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= enter_hold;
      if (enter_hold) begin
        sample   <= shreg;
        null_err <= nerr_acc;
      end
    end
  end
`endif

endmodule

// File: tb/tb_adc_serial_reader.sv
// tb_adc_serial_reader: randomized self-checking bench for adc_serial_reader with a
// behavioural ADC pin model; follows ADC_READER_AVG_EN when defined.
`timescale 1ns/1ps
module tb_adc_serial_reader;

  localparam int CLK_DIV = 4;
  localparam int SB      = 1;
  localparam int DW      = 8;
  localparam int N       = SB + DW;
`ifdef ADC_READER_AVG_EN
  localparam int K = 4;
`else
  localparam int K = 1;
`endif
  localparam int VALID  = 1 + CLK_DIV + 2*CLK_DIV*N + (K-1)*2*CLK_DIV*(N+1);
  localparam int BFALL  = VALID + CLK_DIV;
  localparam int DIV6   = 6;
  localparam int VALID6 = 1 + DIV6 + 2*DIV6*N + (K-1)*2*DIV6*(N+1);

  typedef struct packed {
    logic       nul;
    logic [7:0] data;
  } frame_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, adc_do, adc_cs_n, adc_sclk, sample_valid, null_err, busy;
  logic [7:0] sample;
  logic       start6, adc_do6, adc_cs_n6, adc_sclk6, sample_valid6, null_err6, busy6;
  logic [7:0] sample6;

  int     cyc = 0;
  int     n_cmp = 0;
  int     n_fail = 0;
  frame_t adc_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  adc_serial_reader #(.CLK_DIV(CLK_DIV), .SETUP_BITS(SB), .DATA_W(DW)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .adc_do(adc_do), .adc_cs_n(adc_cs_n),
    .adc_sclk(adc_sclk), .sample(sample), .sample_valid(sample_valid),
    .null_err(null_err), .busy(busy)
  );

  adc_serial_reader #(.CLK_DIV(DIV6), .SETUP_BITS(SB), .DATA_W(DW)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .start(start6), .adc_do(adc_do6), .adc_cs_n(adc_cs_n6),
    .adc_sclk(adc_sclk6), .sample(sample6), .sample_valid(sample_valid6),
    .null_err(null_err6), .busy(busy6)
  );

  assign adc_do6 = 1'b0;

  // ADC pin model: first bit appears when cs_n falls, next bit on every falling sclk.
  initial begin : adc_model
    frame_t         f;
    logic [N-1:0]   bits;
    int             idx;
    adc_do = 1'b0;
    forever begin
      @(negedge adc_cs_n);
      f = (adc_q.size() > 0) ? adc_q.pop_front() : '0;
      bits = {{SB{f.nul}}, f.data};
      idx = 0;
      adc_do = bits[N-1];
      while (adc_cs_n === 1'b0) begin
        @(negedge adc_sclk or posedge adc_cs_n);
        if (adc_cs_n === 1'b0 && idx < N-1) begin
          idx++;
          adc_do = bits[N-1-idx];
        end
      end
      adc_do = 1'($urandom);
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (adc_cs_n !== 1'b1) begin n_fail++; $display("FAIL reset_cs_n got %b want 1", adc_cs_n); end
    n_cmp++; if (adc_sclk !== 1'b0) begin n_fail++; $display("FAIL reset_sclk got %b want 0", adc_sclk); end
    n_cmp++; if (sample !== 8'h00) begin n_fail++; $display("FAIL reset_sample got %h want 00", sample); end
    n_cmp++; if (sample_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", sample_valid); end
    n_cmp++; if (null_err !== 1'b0) begin n_fail++; $display("FAIL reset_null_err got %b want 0", null_err); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (adc_cs_n !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL idle_after_reset cs_n=%b busy=%b want 1/0", adc_cs_n, busy);
    end
  endtask

  task automatic convert_and_check(input string name, input logic [31:0] words,
                                   input logic [3:0] nuls, input int repulse_at);
    int         t0, rel, cs_low_at, vcount, vcyc, bfall, sum;
    logic       busy1, vn, exp_n;
    logic [7:0] vs, exp_s;
    frame_t     f;
    sum = 0; exp_n = 1'b0;
    for (int i = 0; i < K; i++) begin
      f.nul = nuls[i];
      f.data = words[i*8 +: 8];
      adc_q.push_back(f);
      sum += int'(words[i*8 +: 8]);
      exp_n |= nuls[i];
    end
    exp_s = 8'(sum / K);
    @(posedge clk); #1 start = 1'b1; t0 = cyc;
    @(posedge clk); #1 start = 1'b0;
    cs_low_at = -1; vcount = 0; vcyc = -1; bfall = -1; busy1 = 1'b0;
    vs = '0; vn = 1'b0; rel = 0;
    while (rel < BFALL + 3) begin
      @(negedge clk);
      rel = cyc - t0;
      if (rel == repulse_at) start = 1'b1;
      else if (rel == repulse_at + 1) start = 1'b0;
      if (rel == 1) busy1 = busy;
      if (cs_low_at < 0 && adc_cs_n === 1'b0) cs_low_at = rel;
      if (sample_valid === 1'b1) begin vcount++; vcyc = rel; vs = sample; vn = null_err; end
      if (bfall < 0 && rel > 1 && busy === 1'b0) bfall = rel;
    end
    n_cmp++; if (busy1 !== 1'b1) begin n_fail++; $display("FAIL %s busy_cycle1 got %b want 1", name, busy1); end
    n_cmp++; if (cs_low_at != 1) begin n_fail++; $display("FAIL %s cs_low_cycle got %0d want 1", name, cs_low_at); end
    n_cmp++; if (vcount != 1) begin n_fail++; $display("FAIL %s valid_count got %0d want 1", name, vcount); end
    n_cmp++; if (vcyc != VALID) begin n_fail++; $display("FAIL %s valid_cycle got %0d want %0d", name, vcyc, VALID); end
    n_cmp++; if (vs !== exp_s) begin n_fail++; $display("FAIL %s sample got %h want %h", name, vs, exp_s); end
    n_cmp++; if (vn !== exp_n) begin n_fail++; $display("FAIL %s null_err got %b want %b", name, vn, exp_n); end
    n_cmp++; if (bfall != BFALL) begin n_fail++; $display("FAIL %s busy_fall got %0d want %0d", name, bfall, BFALL); end
    n_cmp++; if (sample !== exp_s) begin n_fail++; $display("FAIL %s sample_held got %h want %h", name, sample, exp_s); end
  endtask

  task automatic test_basic();
    convert_and_check("basic_a5", {4{8'hA5}}, 4'b0000, -1);
  endtask

  task automatic test_null_err();
    convert_and_check("null_3c", {4{8'h3C}}, 4'b0001, -1);
  endtask

  task automatic test_ignore_start();
    convert_and_check("ignore_start", $urandom, 4'b0000, 40);
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++) begin
      convert_and_check("random", $urandom, 4'($urandom), -1);
    end
  endtask

  task automatic test_back_to_back();
    int         t0, rel, nval, idle_cnt;
    int         vcyc[2];
    logic [7:0] vs[2], exp_s[2];
    logic       vn[2], exp_n[2];
    frame_t     f;
    for (int g = 0; g < 2; g++) begin
      int sum;
      sum = 0; exp_n[g] = 1'b0;
      for (int i = 0; i < K; i++) begin
        f.nul = 1'($urandom);
        f.data = 8'($urandom);
        adc_q.push_back(f);
        sum += int'(f.data);
        exp_n[g] |= f.nul;
      end
      exp_s[g] = 8'(sum / K);
      vcyc[g] = -1; vs[g] = '0; vn[g] = 1'b0;
    end
    @(posedge clk); #1 start = 1'b1; t0 = cyc;
    nval = 0; idle_cnt = 0; rel = 0;
    while (rel < 2*BFALL + 3) begin
      @(negedge clk);
      rel = cyc - t0;
      if (rel == BFALL + 1) start = 1'b0;
      if (sample_valid === 1'b1) begin
        if (nval < 2) begin vcyc[nval] = rel; vs[nval] = sample; vn[nval] = null_err; end
        nval++;
      end
      if (rel >= 1 && rel < 2*BFALL && busy === 1'b0) idle_cnt++;
    end
    start = 1'b0;
    n_cmp++; if (nval != 2) begin n_fail++; $display("FAIL b2b valid_count got %0d want 2", nval); end
    n_cmp++; if (idle_cnt != 1) begin n_fail++; $display("FAIL b2b idle_cycles got %0d want 1", idle_cnt); end
    n_cmp++; if (vcyc[0] != VALID) begin n_fail++; $display("FAIL b2b valid0_cycle got %0d want %0d", vcyc[0], VALID); end
    n_cmp++; if (vcyc[1] != BFALL + VALID) begin n_fail++; $display("FAIL b2b valid1_cycle got %0d want %0d", vcyc[1], BFALL + VALID); end
    for (int g = 0; g < 2; g++) begin
      n_cmp++; if (vs[g] !== exp_s[g]) begin n_fail++; $display("FAIL b2b sample%0d got %h want %h", g, vs[g], exp_s[g]); end
      n_cmp++; if (vn[g] !== exp_n[g]) begin n_fail++; $display("FAIL b2b null_err%0d got %b want %b", g, vn[g], exp_n[g]); end
    end
  endtask

  task automatic test_midreset();
    int     t0, vcount;
    frame_t f;
    for (int i = 0; i < K; i++) begin
      f.nul = 1'b0;
      f.data = 8'($urandom);
      adc_q.push_back(f);
    end
    @(posedge clk); #1 start = 1'b1; t0 = cyc;
    @(posedge clk); #1 start = 1'b0;
    while (cyc - t0 < 50) @(negedge clk);
    n_cmp++; if (adc_cs_n !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL midrst_active cs_n=%b busy=%b want 0/1", adc_cs_n, busy);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (adc_cs_n !== 1'b1) begin n_fail++; $display("FAIL midrst_cs_n got %b want 1", adc_cs_n); end
    n_cmp++; if (adc_sclk !== 1'b0) begin n_fail++; $display("FAIL midrst_sclk got %b want 0", adc_sclk); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b want 0", busy); end
    n_cmp++; if (sample !== 8'h00) begin n_fail++; $display("FAIL midrst_sample got %h want 00", sample); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    adc_q.delete();
    vcount = 0;
    repeat (100) begin
      @(negedge clk);
      if (sample_valid === 1'b1) vcount++;
    end
    n_cmp++; if (vcount != 0) begin n_fail++; $display("FAIL midrst_no_valid got %0d want 0", vcount); end
    n_cmp++; if (sample !== 8'h00) begin n_fail++; $display("FAIL midrst_sample_after got %h want 00", sample); end
    convert_and_check("after_reset", $urandom, 4'($urandom), -1);
  endtask

  task automatic test_sclk6();
    int   t0, rel, rises, hi_run, lo_run, first_rise, vcyc, vcount;
    logic prev;
    @(posedge clk); #1 start6 = 1'b1; t0 = cyc;
    @(posedge clk); #1 start6 = 1'b0;
    rises = 0; hi_run = 0; lo_run = 0; first_rise = -1; vcyc = -1; vcount = 0;
    prev = 1'b0; rel = 0;
    while (rel < VALID6 + DIV6 + 3) begin
      @(negedge clk);
      rel = cyc - t0;
      if (adc_sclk6 === 1'b1 && prev === 1'b0) begin
        rises++;
        if (first_rise < 0) first_rise = rel;
      end
      if (adc_sclk6 === 1'b1) hi_run++;
      else if (hi_run > 0) begin
        n_cmp++; if (hi_run != DIV6) begin n_fail++; $display("FAIL sclk6_high_len got %0d want %0d", hi_run, DIV6); end
        hi_run = 0;
      end
      if (adc_sclk6 === 1'b0 && adc_cs_n6 === 1'b0) lo_run++;
      else if (lo_run > 0) begin
        n_cmp++; if (lo_run != DIV6) begin n_fail++; $display("FAIL sclk6_low_len got %0d want %0d", lo_run, DIV6); end
        lo_run = 0;
      end
      if (sample_valid6 === 1'b1) begin vcount++; vcyc = rel; end
      prev = adc_sclk6;
    end
    n_cmp++; if (rises != N*K) begin n_fail++; $display("FAIL sclk6_rises got %0d want %0d", rises, N*K); end
    n_cmp++; if (first_rise != 1 + DIV6) begin n_fail++; $display("FAIL sclk6_first_rise got %0d want %0d", first_rise, 1 + DIV6); end
    n_cmp++; if (vcount != 1) begin n_fail++; $display("FAIL sclk6_valid_count got %0d want 1", vcount); end
    n_cmp++; if (vcyc != VALID6) begin n_fail++; $display("FAIL sclk6_valid_cycle got %0d want %0d", vcyc, VALID6); end
  endtask

`ifdef ADC_READER_AVG_EN
  task automatic test_avg();
    convert_and_check("avg_10_11_12_14", {8'h14, 8'h12, 8'h11, 8'h10}, 4'b0000, -1);
    convert_and_check("avg_null_one", {8'hFF, 8'hFE, 8'h01, 8'h00}, 4'b0100, -1);
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    start6 = 1'b0;
    test_reset();
    test_basic();
    test_null_err();
    test_ignore_start();
    test_random();
    test_back_to_back();
    test_midreset();
    test_sclk6();
`ifdef ADC_READER_AVG_EN
    test_avg();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
